// File: rtl/bcd_seq_conv.sv
// Sequential signed-binary to packed-BCD converter (double-dabble, one bit per clock).
// Holds the last completed result stable while a new conversion runs.
module bcd_seq_conv #(
    parameter int unsigned BIN_W  = 9,
    parameter int unsigned DIGITS = 3,
    parameter bit          AUTO   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  start,
    input  logic [BIN_W-1:0]      value_in,
    output logic                  busy,
    output logic                  done,
    output logic                  sign_out,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    if ((64'd1 << (BIN_W - 1)) > (pow10(DIGITS) - 1)) begin : g_range_check
        $error("bcd_seq_conv: DIGITS too small for the magnitude range of BIN_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   last_val;
    logic [BIN_W-1:0]   mag;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic               sign_r;
    logic               trigger;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        trigger    = start || (AUTO && (value_in != last_val));
        case (state)
            IDLE:    if (trigger) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that would overflow past 9 when doubled.
    always_comb begin
        acc_adj = acc;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            last_val <= '0;
            mag      <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_r   <= 1'b0;
            bcd_out  <= '0;
            sign_out <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= (state == FINISH);
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (trigger) begin
                        last_val <= value_in;
                        sign_r   <= value_in[BIN_W-1];
                        // Unsigned BIN_W-bit negation: the most negative input maps to 2^(BIN_W-1).
                        mag      <= value_in[BIN_W-1] ? (~value_in + 1'b1) : value_in;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    {acc, mag} <= {acc_adj[BCD_W-2:0], mag, 1'b0};
                    cnt        <= cnt + 1'b1;
                end
                FINISH: begin
                    bcd_out  <= acc;
                    sign_out <= sign_r && (acc != '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: one AUTO=0 and one AUTO=1 instance checked every cycle
// against a cycle-count/arithmetic model, plus directed literal checks.
module tb_bcd_seq_conv;

    logic        CLK;
    logic        RSTn;
    logic        start0, start1;
    logic [8:0]  value_in0, value_in1;
    logic        busy0, done0, sign0;
    logic        busy1, done1, sign1;
    logic [11:0] bcd0, bcd1;

    int n_cmp = 0;
    int n_err = 0;
    int done1_cnt = 0;

    bcd_seq_conv #(.BIN_W(9), .DIGITS(3), .AUTO(1'b0)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .start(start0), .value_in(value_in0),
        .busy(busy0), .done(done0), .sign_out(sign0), .bcd_out(bcd0)
    );

    bcd_seq_conv #(.BIN_W(9), .DIGITS(3), .AUTO(1'b1)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .start(start1), .value_in(value_in1),
        .busy(busy1), .done(done1), .sign_out(sign1), .bcd_out(bcd1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int magnitude(input logic [8:0] v);
        return v[8] ? (512 - int'(v)) : int'(v);
    endfunction

    function automatic logic [11:0] to_bcd(input logic [8:0] v);
        int m;
        logic [11:0] r;
        m = magnitude(v);
        r[11:8] = 4'((m / 100) % 10);
        r[7:4]  = 4'((m / 10) % 10);
        r[3:0]  = 4'(m % 10);
        return r;
    endfunction

    // Model: cycles remaining until the result edge, captured value, visible outputs.
    int          m_rem  [2];
    logic [8:0]  m_val  [2];
    logic [8:0]  m_last [2];
    logic [11:0] m_bcd  [2];
    logic        m_sign [2];
    logic        m_done [2];
    logic        mi_start;
    logic [8:0]  mi_val;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_val[i] = '0; m_last[i] = '0;
            m_bcd[i] = '0; m_sign[i] = 1'b0; m_done[i] = 1'b0;
        end
    endtask

    initial model_reset();
    always @(negedge RSTn) model_reset();

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            mi_start = (i == 0) ? start0 : start1;
            mi_val   = (i == 0) ? value_in0 : value_in1;
            if (!RSTn) begin
                model_reset();
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                m_done[i] = 1'b0;
                if (m_rem[i] == 0) begin
                    m_bcd[i]  = to_bcd(m_val[i]);
                    m_sign[i] = m_val[i][8] && (magnitude(m_val[i]) != 0);
                    m_done[i] = 1'b1;
                end
            end else begin
                m_done[i] = 1'b0;
                if (mi_start || (i == 1 && mi_val != m_last[i])) begin
                    m_val[i]  = mi_val;
                    m_last[i] = mi_val;
                    m_rem[i]  = 10;
                end
            end
        end
        #1;
        chk("dut0.busy", 32'(busy0), 32'(m_rem[0] != 0));
        chk("dut0.done", 32'(done0), 32'(m_done[0]));
        chk("dut0.sign", 32'(sign0), 32'(m_sign[0]));
        chk("dut0.bcd",  32'(bcd0),  32'(m_bcd[0]));
        chk("dut1.busy", 32'(busy1), 32'(m_rem[1] != 0));
        chk("dut1.done", 32'(done1), 32'(m_done[1]));
        chk("dut1.sign", 32'(sign1), 32'(m_sign[1]));
        chk("dut1.bcd",  32'(bcd1),  32'(m_bcd[1]));
        if (done1) done1_cnt++;
    end

    task automatic wait_done(input int inst, input int limit, output int n);
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < limit) begin
            @(posedge CLK);
            #1;
            n++;
            got = (inst == 0) ? done0 : done1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout dut%0d: no done within %0d cycles", inst, limit);
        end
    endtask

    task automatic wait_idle0();
        int n;
        n = 0;
        while (busy0 && n < 30) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("idle_wait", 32'(busy0), 32'(0));
    endtask

    task automatic run0(input logic [8:0] v, input logic [11:0] eb, input logic es);
        int n;
        @(negedge CLK);
        value_in0 = v;
        start0 = 1'b1;
        @(posedge CLK);
        #1;
        start0 = 1'b0;
        wait_done(0, 20, n);
        chk("latency", 32'(n), 32'(10));
        chk("dir.bcd", 32'(bcd0), 32'(eb));
        chk("dir.sign", 32'(sign0), 32'(es));
    endtask

    function automatic logic [8:0] pick();
        case ($urandom_range(0, 7))
            0: return 9'd0;
            1: return 9'd1;
            2: return 9'h100;
            3: return 9'h1FF;
            4: return 9'd255;
            5: return 9'h101;
            default: return 9'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        RSTn = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        value_in0 = '0; value_in1 = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.busy", 32'(busy0), 32'(0));
        chk("rst.done", 32'(done0), 32'(0));
        chk("rst.bcd",  32'(bcd0),  32'(0));
        chk("rst.sign", 32'(sign0), 32'(0));
        @(negedge CLK);
        RSTn = 1'b1;

        run0(9'd123, 12'h123, 1'b0);
        run0(9'h100, 12'h256, 1'b1);
        run0(9'h1FF, 12'h001, 1'b1);
        run0(9'd0,   12'h000, 1'b0);
        run0(9'd255, 12'h255, 1'b0);
        run0(9'h19D, 12'h099, 1'b1);

        // start held high; value changes mid-flight
        @(negedge CLK);
        value_in0 = 9'd77;
        start0 = 1'b1;
        @(posedge CLK);
        #1;
        repeat (3) @(posedge CLK);
        #1;
        value_in0 = 9'h1F6;
        wait_done(0, 20, n);
        chk("hold.bcd1", 32'(bcd0), 32'(12'h077));
        chk("hold.sign1", 32'(sign0), 32'(0));
        wait_done(0, 20, n);
        start0 = 1'b0;
        chk("hold.lat2", 32'(n), 32'(11));
        chk("hold.bcd2", 32'(bcd0), 32'(12'h010));
        chk("hold.sign2", 32'(sign0), 32'(1));

        // AUTO instance: 0 -> 47 -> 47 -> -99
        done1_cnt = 0;
        @(negedge CLK);
        value_in1 = 9'd47;
        wait_done(1, 20, n);
        chk("auto.lat", 32'(n), 32'(11));
        chk("auto.bcd1", 32'(bcd1), 32'(12'h047));
        chk("auto.sign1", 32'(sign1), 32'(0));
        repeat (15) @(negedge CLK);
        value_in1 = 9'd47;
        repeat (15) @(negedge CLK);
        value_in1 = 9'h19D;
        wait_done(1, 20, n);
        chk("auto.bcd2", 32'(bcd1), 32'(12'h099));
        chk("auto.sign2", 32'(sign1), 32'(1));
        repeat (15) @(negedge CLK);
        chk("auto.count", 32'(done1_cnt), 32'(2));

        // randomized traffic on both instances
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0) value_in0 = pick();
            start0 = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) value_in1 = pick();
            start1 = ($urandom_range(0, 31) == 0);
        end
        @(negedge CLK);
        start0 = 1'b0;
        start1 = 1'b0;
        value_in1 = '0;
        wait_idle0();

        // reset in the middle of a conversion
        run0(9'd255, 12'h255, 1'b0);
        @(negedge CLK);
        value_in0 = 9'd200;
        start0 = 1'b1;
        @(posedge CLK);
        #1;
        start0 = 1'b0;
        repeat (4) @(posedge CLK);
        #3;
        RSTn = 1'b0;
        #1;
        chk("arst.busy", 32'(busy0), 32'(0));
        chk("arst.done", 32'(done0), 32'(0));
        chk("arst.bcd",  32'(bcd0),  32'(0));
        chk("arst.sign", 32'(sign0), 32'(0));
        chk("arst.bcd1", 32'(bcd1),  32'(0));
        @(negedge CLK);
        RSTn = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge CLK);
            #1;
            chk("post_rst.busy", 32'(busy0), 32'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
